// File: rtl/rename_regfile_pkg.sv
// Shared rename-table parameters and types, also used by issue, ROB and RS logic.
package rename_regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_NRD   = 4;
    localparam int DEF_NCMT  = 2;
    localparam int REG_AW    = $clog2(DEF_NREG);

    typedef logic [DEF_TAG_W-1:0] tag_t;
    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [DEF_XLEN-1:0]  data_t;

endpackage

// File: rtl/rename_regfile_if.sv
// Issue, commit and read-port signals of the rename register file.
interface rename_regfile_if
    import rename_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = DEF_NRD,
    parameter int NCMT  = DEF_NCMT
);
    localparam int AW = $clog2(NREG);

    logic             rdy_in;
    logic             flush_in;
    logic             iss_en_in;
    logic [AW-1:0]    iss_rd_in;
    logic [TAG_W-1:0] iss_tag_in;
    logic             cmt_en_in   [NCMT];
    logic [AW-1:0]    cmt_rd_in   [NCMT];
    logic [TAG_W-1:0] cmt_tag_in  [NCMT];
    logic [XLEN-1:0]  cmt_data_in [NCMT];
    logic             rd_en_in    [NRD];
    logic [AW-1:0]    rd_addr_in  [NRD];
    logic             rd_busy_out [NRD];
    logic [TAG_W-1:0] rd_tag_out  [NRD];
    logic [XLEN-1:0]  rd_data_out [NRD];

    modport master (
        output rdy_in, flush_in, iss_en_in, iss_rd_in, iss_tag_in,
        output cmt_en_in, cmt_rd_in, cmt_tag_in, cmt_data_in,
        output rd_en_in, rd_addr_in,
        input  rd_busy_out, rd_tag_out, rd_data_out
    );

    modport slave (
        input  rdy_in, flush_in, iss_en_in, iss_rd_in, iss_tag_in,
        input  cmt_en_in, cmt_rd_in, cmt_tag_in, cmt_data_in,
        input  rd_en_in, rd_addr_in,
        output rd_busy_out, rd_tag_out, rd_data_out
    );

endinterface

// File: rtl/rename_regfile_rdport.sv
// One combinational read port: stored-state mux plus same-cycle commit bypass.
module rename_regfile_rdport #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NCMT  = 2
) (
    input  logic                     en_i,
    input  logic [$clog2(NREG)-1:0]  addr_i,
    input  logic                     byp_en_i,
    input  logic                     iss_en_i,
    input  logic [$clog2(NREG)-1:0]  iss_rd_i,
    input  logic [XLEN-1:0]          data_i     [NREG],
    input  logic [NREG-1:0]          busy_i,
    input  logic [TAG_W-1:0]         tag_i      [NREG],
    input  logic                     cmt_en_i   [NCMT],
    input  logic [$clog2(NREG)-1:0]  cmt_rd_i   [NCMT],
    input  logic [TAG_W-1:0]         cmt_tag_i  [NCMT],
    input  logic [XLEN-1:0]          cmt_data_i [NCMT],
    output logic                     busy_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic [XLEN-1:0]          data_o
);
    logic             s_busy;
    logic [TAG_W-1:0] s_tag;
    logic [XLEN-1:0]  byp_data;
    logic             clr;

    // Later commit ports are younger, so the loop order lets them win the data.
    always_comb begin
        s_busy   = busy_i[addr_i];
        s_tag    = tag_i[addr_i];
        byp_data = data_i[addr_i];
        clr      = 1'b0;
        for (int k = 0; k < NCMT; k++) begin
            if (byp_en_i && cmt_en_i[k] && cmt_rd_i[k] == addr_i) begin
                byp_data = cmt_data_i[k];
                if (s_busy && s_tag == cmt_tag_i[k]) begin
                    clr = 1'b1;
                end
            end
        end
        if (iss_en_i && iss_rd_i == addr_i) begin
            clr = 1'b0;
        end
        busy_o = 1'b0;
        tag_o  = '0;
        data_o = '0;
        if (en_i && addr_i != '0) begin
            busy_o = s_busy & ~clr;
            tag_o  = s_tag;
            data_o = byp_data;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename busy/tag state and commit bypass.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = DEF_NRD,
    parameter int NCMT  = DEF_NCMT
) (
    input  logic           clk_in,
    input  logic           rstn_in,
    rename_regfile_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  data_q [NREG];
    logic [XLEN-1:0]  data_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];

    logic             upd;
    logic             iss_live;
    logic             clr;
    logic             cmt_en   [NCMT];
    logic [AW-1:0]    cmt_rd   [NCMT];
    logic [TAG_W-1:0] cmt_tag  [NCMT];
    logic [XLEN-1:0]  cmt_data [NCMT];
    logic             rd_busy  [NRD];
    logic [TAG_W-1:0] rd_tag   [NRD];
    logic [XLEN-1:0]  rd_data  [NRD];

    always_comb begin
        upd      = bus.rdy_in | bus.flush_in;
        iss_live = bus.iss_en_in & ~bus.flush_in;
        for (int k = 0; k < NCMT; k++) begin
            cmt_en[k]   = bus.cmt_en_in[k];
            cmt_rd[k]   = bus.cmt_rd_in[k];
            cmt_tag[k]  = bus.cmt_tag_in[k];
            cmt_data[k] = bus.cmt_data_in[k];
        end
    end

    // Register 0 is skipped so it keeps its reset value forever; issue beats commit-clear.
    always_comb begin
        clr = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            data_d[r] = data_q[r];
            busy_d[r] = busy_q[r];
            tag_d[r]  = tag_q[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (upd) begin
                clr = 1'b0;
                for (int k = 0; k < NCMT; k++) begin
                    if (cmt_en[k] && cmt_rd[k] == AW'(r)) begin
                        data_d[r] = cmt_data[k];
                        if (busy_q[r] && tag_q[r] == cmt_tag[k]) begin
                            clr = 1'b1;
                        end
                    end
                end
                if (bus.flush_in) begin
                    busy_d[r] = 1'b0;
                end else if (bus.iss_en_in && bus.iss_rd_in == AW'(r)) begin
                    busy_d[r] = 1'b1;
                    tag_d[r]  = bus.iss_tag_in;
                end else if (clr) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rename_regfile_rdport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .TAG_W(TAG_W),
            .NCMT (NCMT)
        ) u_rdport (
            .en_i      (bus.rd_en_in[p]),
            .addr_i    (bus.rd_addr_in[p]),
            .byp_en_i  (upd),
            .iss_en_i  (iss_live),
            .iss_rd_i  (bus.iss_rd_in),
            .data_i    (data_q),
            .busy_i    (busy_q),
            .tag_i     (tag_q),
            .cmt_en_i  (cmt_en),
            .cmt_rd_i  (cmt_rd),
            .cmt_tag_i (cmt_tag),
            .cmt_data_i(cmt_data),
            .busy_o    (rd_busy[p]),
            .tag_o     (rd_tag[p]),
            .data_o    (rd_data[p])
        );
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            bus.rd_busy_out[p] = rd_busy[p];
            bus.rd_tag_out[p]  = rd_tag[p];
            bus.rd_data_out[p] = rd_data[p];
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: vector table plus directed flush/reset sequences.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    rename_regfile_if bus ();

    rename_regfile dut (
        .clk_in (clk),
        .rstn_in(rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      iss_en;
        reg_addr_t iss_rd;
        tag_t      iss_tag;
        logic      c0_en;
        reg_addr_t c0_rd;
        tag_t      c0_tag;
        data_t     c0_data;
        logic      c1_en;
        reg_addr_t c1_rd;
        tag_t      c1_tag;
        data_t     c1_data;
        logic      flush;
        logic      rdy;
        reg_addr_t addr;
        logic      exp_busy;
        tag_t      exp_tag;
        data_t     exp_data;
    } vec_t;

    typedef struct {
        string name;
        int    port;
        logic  busy;
        tag_t  tag;
        data_t data;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    function automatic vec_t mk(input logic ie, input reg_addr_t ir, input tag_t it,
                                input logic c0e, input reg_addr_t c0r, input tag_t c0t, input data_t c0d,
                                input logic c1e, input reg_addr_t c1r, input tag_t c1t, input data_t c1d,
                                input logic fl, input logic rd, input reg_addr_t a,
                                input logic eb, input tag_t et, input data_t ed);
        vec_t v;
        v.iss_en = ie;  v.iss_rd = ir;  v.iss_tag = it;
        v.c0_en = c0e;  v.c0_rd = c0r;  v.c0_tag = c0t;  v.c0_data = c0d;
        v.c1_en = c1e;  v.c1_rd = c1r;  v.c1_tag = c1t;  v.c1_data = c1d;
        v.flush = fl;   v.rdy = rd;     v.addr = a;
        v.exp_busy = eb; v.exp_tag = et; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle();
        bus.rdy_in     = 1'b1;
        bus.flush_in   = 1'b0;
        bus.iss_en_in  = 1'b0;
        bus.iss_rd_in  = '0;
        bus.iss_tag_in = '0;
        for (int k = 0; k < DEF_NCMT; k++) begin
            bus.cmt_en_in[k]   = 1'b0;
            bus.cmt_rd_in[k]   = '0;
            bus.cmt_tag_in[k]  = '0;
            bus.cmt_data_in[k] = '0;
        end
        for (int p = 0; p < DEF_NRD; p++) begin
            bus.rd_en_in[p]   = 1'b0;
            bus.rd_addr_in[p] = '0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        idle();
        bus.rdy_in         = v.rdy;
        bus.flush_in       = v.flush;
        bus.iss_en_in      = v.iss_en;
        bus.iss_rd_in      = v.iss_rd;
        bus.iss_tag_in     = v.iss_tag;
        bus.cmt_en_in[0]   = v.c0_en;
        bus.cmt_rd_in[0]   = v.c0_rd;
        bus.cmt_tag_in[0]  = v.c0_tag;
        bus.cmt_data_in[0] = v.c0_data;
        bus.cmt_en_in[1]   = v.c1_en;
        bus.cmt_rd_in[1]   = v.c1_rd;
        bus.cmt_tag_in[1]  = v.c1_tag;
        bus.cmt_data_in[1] = v.c1_data;
    endtask

    task automatic expectRead(input string name, input int port, input logic en, input reg_addr_t addr,
                              input logic busy, input tag_t tag, input data_t data);
        exp_t e;
        bus.rd_en_in[port]   = en;
        bus.rd_addr_in[port] = addr;
        e.name = name; e.port = port; e.busy = busy; e.tag = tag; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #2;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (bus.rd_busy_out[e.port] !== e.busy || bus.rd_tag_out[e.port] !== e.tag ||
                bus.rd_data_out[e.port] !== e.data) begin
                bad++;
                $display("[TB] FAIL %s port%0d: got busy=%0b tag=%0d data=%h, want busy=%0b tag=%0d data=%h",
                         e.name, e.port, bus.rd_busy_out[e.port], bus.rd_tag_out[e.port],
                         bus.rd_data_out[e.port], e.busy, e.tag, e.data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        idle();

        //                  iss           c0                       c1                        fl rdy addr  busy tag data
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   1, 0, 0, 32'hDEAD,     0, 0, 0, 32'h0,          0, 1, 0,  0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 0,  0, 0,  32'h0));
        vecs.push_back(mk(1, 5, 3,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   1, 5, 3, 32'h1234,     0, 0, 0, 32'h0,          0, 1, 5,  0, 3,  32'h1234));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  0, 3,  32'h1234));
        vecs.push_back(mk(1, 5, 3,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  0, 3,  32'h1234));
        vecs.push_back(mk(1, 5, 7,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  1, 3,  32'h1234));
        vecs.push_back(mk(0, 0, 0,   1, 5, 3, 32'h11,       0, 0, 0, 32'h0,          0, 1, 5,  1, 7,  32'h11));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  1, 7,  32'h11));
        vecs.push_back(mk(1, 6, 1,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 6,  0, 0,  32'h0));
        vecs.push_back(mk(1, 6, 2,   1, 6, 1, 32'h55,       0, 0, 0, 32'h0,          0, 1, 6,  1, 1,  32'h55));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 6,  1, 2,  32'h55));
        vecs.push_back(mk(1, 7, 5,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 7,  0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   1, 7, 4, 32'hA,        1, 7, 5, 32'hB,          0, 1, 7,  0, 5,  32'hB));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 7,  0, 5,  32'hB));
        vecs.push_back(mk(1, 8, 9,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 8,  0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   1, 8, 9, 32'hC0,       1, 8, 2, 32'hC1,         0, 1, 8,  0, 9,  32'hC1));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 8,  0, 9,  32'hC1));
        vecs.push_back(mk(1, 9, 4,   1, 5, 7, 32'h77,       0, 0, 0, 32'h0,          0, 0, 5,  1, 7,  32'h11));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 5,  1, 7,  32'h11));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 9,  0, 0,  32'h0));
        vecs.push_back(mk(1, 31, 15, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 31, 0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        1, 31, 15, 32'hFFFFFFFF, 0, 1, 31, 0, 15, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 1, 31, 0, 15, 32'hFFFFFFFF));

        // Reset state, including a disabled port.
        @(negedge clk);
        expectRead("rst_x5", 0, 1, 5, 0, 0, 32'h0);
        expectRead("rst_x0", 1, 1, 0, 0, 0, 32'h0);
        expectRead("rst_x31", 2, 1, 31, 0, 0, 32'h0);
        expectRead("rst_dis", 3, 0, 5, 0, 0, 32'h0);
        checkOutput();
        rstn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            expectRead($sformatf("vec%0d", i), 0, 1, vecs[i].addr, vecs[i].exp_busy, vecs[i].exp_tag, vecs[i].exp_data);
            checkOutput();
        end

        // Rename x1..x4, then flush while stalled with a commit to x2 and a stray issue.
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            idle();
            bus.iss_en_in  = 1'b1;
            bus.iss_rd_in  = reg_addr_t'(r);
            bus.iss_tag_in = tag_t'(r);
        end
        @(negedge clk);
        idle();
        expectRead("preflush_x3", 0, 1, 3, 1, 3, 32'h0);
        checkOutput();
        @(negedge clk);
        idle();
        bus.rdy_in         = 1'b0;
        bus.flush_in       = 1'b1;
        bus.iss_en_in      = 1'b1;
        bus.iss_rd_in      = 10;
        bus.iss_tag_in     = 6;
        bus.cmt_en_in[0]   = 1'b1;
        bus.cmt_rd_in[0]   = 2;
        bus.cmt_tag_in[0]  = 0;
        bus.cmt_data_in[0] = 32'h99;
        expectRead("flush_byp_x2", 0, 1, 2, 1, 2, 32'h99);
        checkOutput();
        @(negedge clk);
        idle();
        expectRead("flush_x1", 0, 1, 1, 0, 1, 32'h0);
        expectRead("flush_x2", 1, 1, 2, 0, 2, 32'h99);
        expectRead("flush_x3", 2, 1, 3, 0, 3, 32'h0);
        expectRead("flush_x4", 3, 1, 4, 0, 4, 32'h0);
        checkOutput();
        @(negedge clk);
        idle();
        expectRead("flush_x5", 0, 1, 5, 0, 7, 32'h11);
        expectRead("flush_x10", 1, 1, 10, 0, 0, 32'h0);
        expectRead("flush_x6", 2, 1, 6, 0, 2, 32'h55);
        expectRead("dis_x2", 3, 0, 2, 0, 0, 32'h0);
        checkOutput();

        // Reset asserted mid-cycle with an issue and commit in flight.
        @(negedge clk);
        idle();
        bus.iss_en_in      = 1'b1;
        bus.iss_rd_in      = 12;
        bus.iss_tag_in     = 3;
        bus.cmt_en_in[0]   = 1'b1;
        bus.cmt_rd_in[0]   = 7;
        bus.cmt_tag_in[0]  = 5;
        bus.cmt_data_in[0] = 32'h5;
        #1 rstn = 1'b0;
        expectRead("async_rst_x2", 1, 1, 2, 0, 0, 32'h0);
        checkOutput();
        @(negedge clk);
        expectRead("rst_hold_x12", 2, 1, 12, 0, 0, 32'h0);
        expectRead("rst_hold_x5", 3, 1, 5, 0, 0, 32'h0);
        checkOutput();
        idle();
        rstn = 1'b1;
        @(negedge clk);
        idle();
        expectRead("post_rst_x12", 0, 1, 12, 0, 0, 32'h0);
        expectRead("post_rst_x7", 1, 1, 7, 0, 0, 32'h0);
        expectRead("post_rst_x6", 2, 1, 6, 0, 0, 32'h0);
        bus.iss_en_in  = 1'b1;
        bus.iss_rd_in  = 3;
        bus.iss_tag_in = 1;
        checkOutput();
        @(negedge clk);
        idle();
        expectRead("post_rst_iss_x3", 0, 1, 3, 1, 1, 32'h0);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 The block SHALL take parameters (name, default, meaning): XLEN, 32, data width; NREG, 32, architectural register count (power of 2); TAG_W, 4, ROB tag width; NRD, 4, read port count; NCMT, 2, commit port count.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk_in, in, 1, single clock.
REQ-003 rstn_in, in, 1, asynchronous active-low reset.
REQ-004 rdy_in, in, 1, global stall; low = no state change.
REQ-005 flush_in, in, 1, misprediction flush from commit.
REQ-006 iss_en_in, in, 1, issue renames destination; iss_rd_in, in, log2(NREG); iss_tag_in, in, TAG_W.
REQ-007 cmt_en_in[NCMT], in, 1 each; cmt_rd_in[NCMT], in, log2(NREG); cmt_tag_in[NCMT], in, TAG_W; cmt_data_in[NCMT], in, XLEN. Port NCMT-1 is youngest in program order.
REQ-008 rd_en_in[NRD], in, 1; rd_addr_in[NRD], in, log2(NREG).
REQ-009 rd_busy_out[NRD], out, 1; rd_tag_out[NRD], out, TAG_W; rd_data_out[NRD], out, XLEN.

Function
REQ-010 Per register, state SHALL be data (XLEN), busy (1), tag (TAG_W); busy replaces the former out-of-range tag sentinel.
REQ-011 Register 0 SHALL never be written, never become busy, always read data 0, busy 0, tag 0.
REQ-012 All state updates SHALL occur on the rising clk_in edge, only when rdy_in=1 or flush_in=1.
REQ-013 Commit port k (en=1, rd≠0) SHALL write cmt_data_in[k] to data[rd] unconditionally.
REQ-014 Commit port k SHALL clear busy[rd] only if busy[rd]=1 and tag[rd]=cmt_tag_in[k] and no same-cycle issue targets rd.
REQ-015 Multiple commit ports to same rd in one cycle: highest-index port's data SHALL win; busy cleared if any matching port tag equals tag[rd].
REQ-016 Issue (iss_en_in=1, rd≠0) SHALL set busy[rd]=1, tag[rd]=iss_tag_in; issue overrides any same-cycle commit busy-clear on that rd.
REQ-017 flush_in=1 SHALL clear every busy bit, ignore issue, and still apply commit data writes of that cycle; flush takes effect regardless of rdy_in.
REQ-018 Reads SHALL be combinational; rd_en_in=0 SHALL drive all three outputs of that port to 0.
REQ-019 Read bypass: if a same-cycle commit would clear busy for rd_addr per REQ-014, port SHALL return busy=0 and the committing data (youngest per REQ-015); if a commit writes data without clearing busy, port SHALL return stored busy/tag and committing data.
REQ-020 Same-cycle issue SHALL NOT be visible to reads (reads see pre-issue rename state); bypass SHALL be suppressed when rdy_in=0 and flush_in=0.
REQ-021 Read latency SHALL be 0 cycles; write-to-read latency 1 cycle (0 with bypass).

Reset
REQ-022 rstn_in=0 SHALL asynchronously clear all data, busy and tag bits to 0; outputs then follow REQ-018/REQ-011 combinationally.
REQ-023 Reset deassertion SHALL be synchronised externally; first update occurs on the first rising edge with rstn_in=1.
REQ-024 Reset asserted mid-operation SHALL discard in-flight issue/commit of that cycle.

Structure
REQ-025 Shared package SHALL hold default XLEN, NREG, TAG_W and the tag and register-address types used by issue, ROB and RS.
REQ-026 One sub-module rename_regfile_rdport SHALL implement the bypass/mux for a single read port, instantiated NRD times.
REQ-027 Storage SHALL be flops (no SRAM); state arrays per REQ-010.

Verification
REQ-028 Reset, then read x5 -> busy 0, tag 0, data 0; read x0 after commit of 0xDEAD to x0 -> data 0.
REQ-029 Issue x5 tag 3; next cycle commit x5 tag 3 data 0x1234 -> same-cycle read busy 0 data 0x1234 (bypass); following cycle stored busy 0 data 0x1234.
REQ-030 Issue x5 tag 3, then issue x5 tag 7, then commit x5 tag 3 data 0x11 -> x5 data 0x11, busy 1, tag 7.
REQ-031 Same cycle: issue x6 tag 2 and commit x6 tag 1 (busy tag 1) data 0x55 -> x6 busy 1 tag 2 data 0x55.
REQ-032 Two commits to x7 same cycle, port0 data 0xA tag 4, port1 data 0xB tag 5, busy tag 5 -> x7 data 0xB busy 0.
REQ-033 Busy x1..x4, flush with commit x2 data 0x99, rdy_in=0 -> all busy 0, x2 data 0x99, no issue applied.
